multicycle_control_fsm: RTL and testbench

//  Multi-cycle main controller that sequences the fetch/decode/execute datapath of the 32-bit MIPS-style core.

---
 rtl/multicycle_control_fsm.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
// Multi-cycle main controller for the 32-bit MIPS-style core. Steps the
// datapath through FETCH/DECODE/EXEC/MEM/WB, one phase per clock, and
// handshakes with instruction and data memory.
//
// Optional feature macro: PERF_COUNTERS_EN (adds cycle_cnt / instr_cnt).
//
// Ports
//   clk, rst_n            core clock (rising edge), async active-low reset
//   run                   fetch permitted (looked at only before a request is issued)
//   opcode, function_code decoded instruction fields, valid from DECODE
//   alu_zero              ALU zero flag, valid in EXEC
//   imem_ack, dmem_ack    memory handshakes
//   imem_req              instruction fetch request
//   ir_load, pc_en        IR latch / PC update strobes
//   pc_sel                00 PC+4, 01 branch target, 10 jump target
//   alu_op, alu_src_imm   ALU function and B-operand select
//   reg_dst, reg_write    register-file destination select / write strobe
//   mem_to_reg            writeback data from memory
//   dmem_req, dmem_we     data memory request / write qualifier
//   illegal_op            unsupported opcode/function pulse
//   state                 current state (debug)
//   cycle_cnt, instr_cnt  performance counters (PERF_COUNTERS_EN only)
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic [5:0]         opcode,
    input  logic [5:0]         function_code,
    input  logic               alu_zero,
    input  logic               imem_ack,
    input  logic               dmem_ack,
    output logic               imem_req,
    output logic               ir_load,
    output logic               pc_en,
    output logic [1:0]         pc_sel,
    output logic [ALUOP_W-1:0] alu_op,
    output logic               alu_src_imm,
    output logic               reg_dst,
    output logic               reg_write,
    output logic               mem_to_reg,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic               illegal_op,
    output logic [2:0]         state
`ifdef PERF_COUNTERS_EN
    ,
    output logic [31:0]        cycle_cnt,
    output logic [31:0]        instr_cnt
`endif
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [2:0] CLS_R    = 3'd0;
    localparam logic [2:0] CLS_LW   = 3'd1;
    localparam logic [2:0] CLS_SW   = 3'd2;
    localparam logic [2:0] CLS_BEQ  = 3'd3;
    localparam logic [2:0] CLS_ADDI = 3'd4;
    localparam logic [2:0] CLS_J    = 3'd5;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLT = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(5);

    logic [2:0]         r_state,  w_state_nxt;
    logic               r_issued, w_issued_nxt;
    logic [2:0]         r_cls,    w_cls_nxt;
    logic [ALUOP_W-1:0] r_alu_op, w_alu_op_nxt;

    logic               w_dec_ok;
    logic [2:0]         w_dec_cls;
    logic [ALUOP_W-1:0] w_dec_alu;
    logic               w_dp_active;

    // State, fetch-issued flag and instruction class registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_issued <= 1'b0;
            r_cls    <= CLS_R;
            r_alu_op <= ALU_ADD;
        end else begin
            r_state  <= w_state_nxt;
            r_issued <= w_issued_nxt;
            r_cls    <= w_cls_nxt;
            r_alu_op <= w_alu_op_nxt;
        end
    end

    // Instruction classifier for opcode/function_code
    always_comb begin
        w_dec_ok  = 1'b1;
        w_dec_cls = CLS_R;
        w_dec_alu = ALU_ADD;
        case (opcode)
            6'h00: begin
                case (function_code)
                    6'h20:   w_dec_alu = ALU_ADD;
                    6'h22:   w_dec_alu = ALU_SUB;
                    6'h24:   w_dec_alu = ALU_AND;
                    6'h25:   w_dec_alu = ALU_OR;
                    6'h2A:   w_dec_alu = ALU_SLT;
                    6'h00:   w_dec_alu = ALU_SLL;
                    default: w_dec_ok  = 1'b0;
                endcase
            end
            6'h23:   w_dec_cls = CLS_LW;
            6'h2B:   w_dec_cls = CLS_SW;
            6'h04: begin
                w_dec_cls = CLS_BEQ;
                w_dec_alu = ALU_SUB;
            end
            6'h08:   w_dec_cls = CLS_ADDI;
            6'h02:   w_dec_cls = CLS_J;
            default: w_dec_ok  = 1'b0;
        endcase
    end

    assign w_dp_active = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

    // Next-state and control decode
    always_comb begin
        w_state_nxt  = r_state;
        w_issued_nxt = r_issued;
        w_cls_nxt    = r_cls;
        w_alu_op_nxt = r_alu_op;
        imem_req     = 1'b0;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_sel       = 2'b00;
        alu_op       = ALU_ADD;
        alu_src_imm  = 1'b0;
        reg_dst      = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        illegal_op   = 1'b0;

        // Datapath selects come from the class latched in DECODE, so they
        // hold steady from EXEC through WB regardless of later opcode changes.
        if (w_dp_active) begin
            alu_op      = r_alu_op;
            alu_src_imm = (r_cls == CLS_LW) || (r_cls == CLS_SW) || (r_cls == CLS_ADDI);
            reg_dst     = (r_cls == CLS_R);
            mem_to_reg  = (r_cls == CLS_LW);
        end

        case (r_state)
            S_FETCH: begin
                // rst_n gate keeps the request low while reset is asserted.
                imem_req = rst_n && (run || r_issued);
                if (imem_req) begin
                    if (imem_ack) begin
                        ir_load      = 1'b1;
                        pc_en        = 1'b1;
                        w_issued_nxt = 1'b0;
                        w_state_nxt  = S_DECODE;
                    end else begin
                        w_issued_nxt = 1'b1;
                    end
                end
            end
            S_DECODE: begin
                if (w_dec_ok) begin
                    w_cls_nxt    = w_dec_cls;
                    w_alu_op_nxt = w_dec_alu;
                    w_state_nxt  = S_EXEC;
                end else begin
                    illegal_op   = 1'b1;
                    w_state_nxt  = S_FETCH;
                end
            end
            S_EXEC: begin
                case (r_cls)
                    CLS_BEQ: begin
                        pc_en       = alu_zero;
                        pc_sel      = 2'b01;
                        w_state_nxt = S_FETCH;
                    end
                    CLS_J: begin
                        pc_en       = 1'b1;
                        pc_sel      = 2'b10;
                        w_state_nxt = S_FETCH;
                    end
                    CLS_R, CLS_ADDI: w_state_nxt = S_WB;
                    CLS_LW, CLS_SW:  w_state_nxt = S_MEM;
                    default:         w_state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (r_cls == CLS_SW);
                if (dmem_ack) begin
                    w_state_nxt = (r_cls == CLS_LW) ? S_WB : S_FETCH;
                end
            end
            S_WB: begin
                reg_write   = 1'b1;
                w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    assign state = r_state;

`ifdef PERF_COUNTERS_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instr_cnt;

    // Free-running cycle counter and retired-fetch counter, both wrap at 2^32
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt <= 32'd0;
            r_instr_cnt <= 32'd0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if ((r_state == S_FETCH) && (w_state_nxt == S_DECODE)) begin
                r_instr_cnt <= r_instr_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt = r_cycle_cnt;
    assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
// Directed self-checking bench for multicycle_control_fsm. Inputs change 1ns
// after the rising edge; outputs are sampled 1ns later, mid-cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  function_code;
    logic        alu_zero;
    logic        imem_ack;
    logic        dmem_ack;
    logic        imem_req;
    logic        ir_load;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [3:0]  alu_op;
    logic        alu_src_imm;
    logic        reg_dst;
    logic        reg_write;
    logic        mem_to_reg;
    logic        dmem_req;
    logic        dmem_we;
    logic        illegal_op;
    logic [2:0]  state;
`ifdef PERF_COUNTERS_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [15:0] outs;
    assign outs = {imem_req, ir_load, pc_en, pc_sel, alu_op, alu_src_imm,
                   reg_dst, reg_write, mem_to_reg, dmem_req, dmem_we, illegal_op};

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ALUOP_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .opcode        (opcode),
        .function_code (function_code),
        .alu_zero      (alu_zero),
        .imem_ack      (imem_ack),
        .dmem_ack      (dmem_ack),
        .imem_req      (imem_req),
        .ir_load       (ir_load),
        .pc_en         (pc_en),
        .pc_sel        (pc_sel),
        .alu_op        (alu_op),
        .alu_src_imm   (alu_src_imm),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .illegal_op    (illegal_op),
        .state         (state)
`ifdef PERF_COUNTERS_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .instr_cnt     (instr_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a zero-wait fetch and leave the FSM settled in DECODE
    task automatic fetch_into_decode(input logic [5:0] opc, input logic [5:0] fn);
        run = 1'b1; imem_ack = 1'b1; opcode = opc; function_code = fn;
        #1;
        @(posedge clk);
        #1;
        run = 1'b0; imem_ack = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b1; opcode = 6'h00; function_code = 6'h20;
        alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        #3;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (outs !== 16'h0) begin errors++; $display("FAIL reset_outs got %h exp 0000", outs); end
        run = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        tick(); #1;
        checks++; if (state !== 3'd0 || imem_req !== 1'b0) begin errors++; $display("FAIL reset_idle state %0d imem_req %b exp 0 0", state, imem_req); end
    endtask

    task automatic test_r_add();
        run = 1'b1; imem_ack = 1'b1; opcode = 6'h00; function_code = 6'h20;
        #1;
        checks++; if ({state, imem_req, ir_load, pc_en, pc_sel} !== {3'd0, 1'b1, 1'b1, 1'b1, 2'b00}) begin errors++; $display("FAIL add_fetch got %b exp 000111_00", {state, imem_req, ir_load, pc_en, pc_sel}); end
        tick(); run = 1'b0; imem_ack = 1'b0; #1;
        checks++; if (state !== 3'd1 || ir_load !== 1'b0 || illegal_op !== 1'b0) begin errors++; $display("FAIL add_decode state %0d ir_load %b illegal %b exp 1 0 0", state, ir_load, illegal_op); end
        tick(); #1;
        checks++; if ({state, alu_op, reg_dst, alu_src_imm, reg_write} !== {3'd2, 4'd0, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL add_exec got %b exp 010_0000_1_0_0", {state, alu_op, reg_dst, alu_src_imm, reg_write}); end
        tick(); #1;
        checks++; if ({state, alu_op, reg_dst, reg_write, mem_to_reg} !== {3'd4, 4'd0, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL add_wb got %b exp 100_0000_1_1_0", {state, alu_op, reg_dst, reg_write, mem_to_reg}); end
        tick(); #1;
        checks++; if (state !== 3'd0 || reg_write !== 1'b0 || imem_req !== 1'b0) begin errors++; $display("FAIL add_done state %0d reg_write %b imem_req %b exp 0 0 0", state, reg_write, imem_req); end
    endtask

    task automatic test_sub_opcode_change();
        fetch_into_decode(6'h00, 6'h22);
        tick(); opcode = 6'h3F; function_code = 6'h00; #1;
        checks++; if (state !== 3'd2 || alu_op !== 4'd1) begin errors++; $display("FAIL sub_exec state %0d alu_op %0d exp 2 1", state, alu_op); end
        tick(); #1;
        checks++; if ({state, alu_op, reg_write, illegal_op} !== {3'd4, 4'd1, 1'b1, 1'b0}) begin errors++; $display("FAIL sub_wb got %b exp 100_0001_1_0", {state, alu_op, reg_write, illegal_op}); end
        tick(); #1;
    endtask

    task automatic test_lw_wait();
        int n, dreq, we_cnt;
        bit done;
        fetch_into_decode(6'h23, 6'h00);
        tick(); #1;
        checks++; if ({state, alu_op, alu_src_imm, mem_to_reg, dmem_req} !== {3'd2, 4'd0, 1'b1, 1'b1, 1'b0}) begin errors++; $display("FAIL lw_exec got %b exp 010_0000_1_1_0", {state, alu_op, alu_src_imm, mem_to_reg, dmem_req}); end
        n = 3; dreq = 0; we_cnt = 0; done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            tick(); dmem_ack = (dreq == 3); #1;
            if (state === 3'd0) begin
                done = 1'b1;
            end else begin
                n++;
                if (dmem_req === 1'b1) dreq++;
                if (dmem_we === 1'b1) we_cnt++;
                if (state === 3'd4) begin
                    checks++; if ({reg_write, mem_to_reg, reg_dst, alu_src_imm} !== 4'b1101) begin errors++; $display("FAIL lw_wb got %b exp 1101", {reg_write, mem_to_reg, reg_dst, alu_src_imm}); end
                end
            end
        end
        dmem_ack = 1'b0;
        checks++; if (!done) begin errors++; $display("FAIL lw_timeout got busy exp FETCH within 20 cycles"); end
        checks++; if (dreq !== 4) begin errors++; $display("FAIL lw_dmem_req_cycles got %0d exp 4", dreq); end
        checks++; if (we_cnt !== 0) begin errors++; $display("FAIL lw_dmem_we got %0d exp 0", we_cnt); end
        checks++; if (n !== 8) begin errors++; $display("FAIL lw_latency got %0d exp 8", n); end
    endtask

    task automatic test_sw();
        fetch_into_decode(6'h2B, 6'h00);
        tick(); #1;
        checks++; if (state !== 3'd2 || alu_src_imm !== 1'b1 || mem_to_reg !== 1'b0) begin errors++; $display("FAIL sw_exec state %0d imm %b m2r %b exp 2 1 0", state, alu_src_imm, mem_to_reg); end
        tick(); dmem_ack = 1'b1; #1;
        checks++; if ({state, dmem_req, dmem_we} !== {3'd3, 1'b1, 1'b1}) begin errors++; $display("FAIL sw_mem got %b exp 011_1_1", {state, dmem_req, dmem_we}); end
        tick(); dmem_ack = 1'b0; #1;
        checks++; if (state !== 3'd0 || reg_write !== 1'b0 || dmem_req !== 1'b0) begin errors++; $display("FAIL sw_done state %0d reg_write %b dmem_req %b exp 0 0 0", state, reg_write, dmem_req); end
    endtask

    task automatic test_beq(input logic zero);
        fetch_into_decode(6'h04, 6'h00);
        tick(); alu_zero = zero; #1;
        checks++; if ({state, alu_op, pc_en, pc_sel} !== {3'd2, 4'd1, zero, 2'b01}) begin errors++; $display("FAIL beq_exec_z%0d got %b exp %b", zero, {state, alu_op, pc_en, pc_sel}, {3'd2, 4'd1, zero, 2'b01}); end
        tick(); alu_zero = 1'b0; #1;
        checks++; if (state !== 3'd0 || pc_en !== 1'b0) begin errors++; $display("FAIL beq_done_z%0d state %0d pc_en %b exp 0 0", zero, state, pc_en); end
    endtask

    task automatic test_j_addi();
        fetch_into_decode(6'h02, 6'h00);
        tick(); #1;
        checks++; if ({state, pc_en, pc_sel, reg_write} !== {3'd2, 1'b1, 2'b10, 1'b0}) begin errors++; $display("FAIL j_exec got %b exp 010_1_10_0", {state, pc_en, pc_sel, reg_write}); end
        tick(); #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL j_done state %0d exp 0", state); end
        fetch_into_decode(6'h08, 6'h00);
        tick(); #1;
        checks++; if ({state, alu_op, alu_src_imm} !== {3'd2, 4'd0, 1'b1}) begin errors++; $display("FAIL addi_exec got %b exp 010_0000_1", {state, alu_op, alu_src_imm}); end
        tick(); #1;
        checks++; if ({state, reg_write, reg_dst, mem_to_reg} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin errors++; $display("FAIL addi_wb got %b exp 100_1_0_0", {state, reg_write, reg_dst, mem_to_reg}); end
        tick(); #1;
    endtask

    task automatic test_illegal();
        fetch_into_decode(6'h3F, 6'h00);
        checks++; if (state !== 3'd1 || illegal_op !== 1'b1) begin errors++; $display("FAIL ill_decode state %0d illegal %b exp 1 1", state, illegal_op); end
        tick(); #1;
        checks++; if ({state, illegal_op, reg_write, dmem_req} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin errors++; $display("FAIL ill_next got %b exp 000_0_0_0", {state, illegal_op, reg_write, dmem_req}); end
        fetch_into_decode(6'h00, 6'h21);
        checks++; if (illegal_op !== 1'b1) begin errors++; $display("FAIL ill_funct got %b exp 1", illegal_op); end
        tick(); #1;
    endtask

    task automatic test_run_hold();
        run = 1'b1; imem_ack = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || ir_load !== 1'b0) begin errors++; $display("FAIL hold_issue imem_req %b ir_load %b exp 1 0", imem_req, ir_load); end
        tick(); run = 1'b0; #1;
        checks++; if (imem_req !== 1'b1 || state !== 3'd0) begin errors++; $display("FAIL hold_run_drop imem_req %b state %0d exp 1 0", imem_req, state); end
        tick(); #1;
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL hold_wait2 imem_req %b exp 1", imem_req); end
        tick(); imem_ack = 1'b1; opcode = 6'h02; #1;
        checks++; if (ir_load !== 1'b1 || pc_en !== 1'b1) begin errors++; $display("FAIL hold_ack ir_load %b pc_en %b exp 1 1", ir_load, pc_en); end
        tick(); imem_ack = 1'b0; #1;
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL hold_decode state %0d exp 1", state); end
        tick(); #1; tick(); #1;
        for (int k = 0; k < 3; k++) begin
            imem_ack = (k == 1); #1;
            checks++; if ({state, imem_req, ir_load} !== {3'd0, 1'b0, 1'b0}) begin errors++; $display("FAIL idle_%0d got %b exp 000_0_0", k, {state, imem_req, ir_load}); end
            tick();
        end
        imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        fetch_into_decode(6'h23, 6'h00);
        tick(); #1;
        tick(); dmem_ack = 1'b0; #1;
        checks++; if (state !== 3'd3 || dmem_req !== 1'b1) begin errors++; $display("FAIL rmem_pre state %0d dmem_req %b exp 3 1", state, dmem_req); end
        #1; rst_n = 1'b0; #1;
        checks++; if (state !== 3'd0 || outs !== 16'h0) begin errors++; $display("FAIL rmem_async state %0d outs %h exp 0 0000", state, outs); end
        @(negedge clk); rst_n = 1'b1;
        tick(); #1;
        checks++; if (state !== 3'd0 || outs !== 16'h0) begin errors++; $display("FAIL rmem_release state %0d outs %h exp 0 0000", state, outs); end
        fetch_into_decode(6'h00, 6'h20);
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL rmem_resume state %0d exp 1", state); end
        tick(); #1; tick(); #1; tick(); #1;
    endtask

`ifdef PERF_COUNTERS_EN
    task automatic test_perf();
        logic [31:0] c0, i0;
        c0 = cycle_cnt; i0 = instr_cnt;
        fetch_into_decode(6'h02, 6'h00);
        tick(); #1; tick(); #1;
        checks++; if (cycle_cnt - c0 !== 32'd3) begin errors++; $display("FAIL perf_cycles got %0d exp 3", cycle_cnt - c0); end
        checks++; if (instr_cnt - i0 !== 32'd1) begin errors++; $display("FAIL perf_instr got %0d exp 1", instr_cnt - i0); end
    endtask
`endif

    initial begin
        test_reset();
        test_r_add();
        test_sub_opcode_change();
        test_lw_wait();
        test_sw();
        test_beq(1'b1);
        test_beq(1'b0);
        test_j_addi();
        test_illegal();
        test_run_hold();
        test_reset_mid_mem();
`ifdef PERF_COUNTERS_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
